nibble_mem_loader: RTL and testbench
====================================

// Module: nibble_mem_loader
// PURPOSE
//  Program/data memory for the 4-bit nibble CPU. Serves the CPU's 12-bit nibble bus
//  (address = {uo_out, uio_out[7:4]}, data on uio[3:0]) with a combinational read.
//  Before the CPU runs, it accepts a byte stream (valid/ready) and fills memory from nibble 0.
//  It holds the CPU in reset until loading completes. Sits directly downstream of the CPU bus pins.
// PARAMETERS
//  MEM_NIBBLES  256  physical depth in nibbles (power of 2); bus/load addresses wrap modulo depth
//  ADDR_W       12   bus address width
// PORTS
//  clk         in   1       clock; all state updates on rising edge
//  rst         in   1       synchronous, active-high reset
//  ld_start    in   1       pulse: restart the load sequence, from any state
//  ld_valid    in   1       loader byte valid
//  ld_data     in   8       loader byte
//  ld_ready    out  1       loader byte accepted when ld_valid && ld_ready at clk edge
//  bus_addr    in   ADDR_W  CPU nibble address
//  bus_we      in   1       CPU write strobe (CPU drives uio_oe[3:0]=1)
//  bus_wdata   in   4       CPU write nibble
//  bus_rdata   out  4       read nibble, combinational from bus_addr
//  cpu_rst     out  1       active-high reset to the CPU; held during load
//  load_done   out  1       high in RUN
//  load_err    out  1       checksum failure (LOADER_CHECKSUM_EN only)
// BEHAVIOUR
//  - States: HDR_LO -> HDR_HI -> DATA_LO <-> DATA_HI -> [CSUM] -> RUN; also ERROR.
//  - Reset: state=HDR_LO, cpu_rst=1, load_done=0, load_err=0, byte count and pointer = 0.
//    Memory contents are not cleared. ld_ready=0 while rst=1.
//  - HDR_LO/HDR_HI: ld_ready=1; each accepted byte sets LEN[7:0] / LEN[11:8] (upper 4 bits ignored).
//  - DATA_LO: ld_ready=1; on accept, writes ld_data[3:0] to mem[ptr], latches the high nibble,
//    ptr++, goes to DATA_HI.
//  - DATA_HI: ld_ready=0; writes the latched nibble to mem[ptr], ptr++, count++.
//    Next state is DATA_LO if count<LEN, otherwise CSUM/RUN. Two cycles per byte, max throughput.
//  - LEN=0: after HDR_HI, goes to CSUM or RUN directly; memory untouched.
//  - ptr wraps at MEM_NIBBLES; LEN*2 > MEM_NIBBLES overwrites from nibble 0 (no error).
//  - RUN: cpu_rst=0 and load_done=1, both registered (first RUN cycle). ld_ready=0.
//    bus_we writes bus_wdata to mem[bus_addr mod depth] at the edge.
//  - bus_rdata = mem[bus_addr mod depth] in every state. bus_we is ignored outside RUN.
//  - Read during write, same address: bus_rdata shows the old nibble; the new one appears next cycle.
//  - ld_start (any state, incl. RUN/ERROR): next state HDR_LO, cpu_rst=1, load_done=0,
//    load_err=0, ptr=count=0. Any byte offered in that same cycle is not accepted (ld_ready=0).
//  - rst mid-load: same as ld_start; partially written memory persists.
// CONFIGURATION
//  LOADER_CHECKSUM_EN defined:
//    - After the data, state CSUM accepts one byte. Pass if it equals XOR of the 2 header bytes
//      and all data bytes: go to RUN.
//    - Fail: go to ERROR (cpu_rst=1, load_err=1, ld_ready=0) until ld_start/rst.
//  Not defined: no CSUM/ERROR states; load_err tied 0.
// STRUCTURE
//  - Package nibble_bus_pkg: state enum (loader_state_t), NIB_W=4, BUS_ADDR_W=12,
//    CPU address-map constants: fetch slot idx 0..2, data slot idx 3.
//  - Sub-module nibble_ram: MEM_NIBBLES x 4, one synchronous write port, one async read port.
//    The top arbitrates its write port between the loader (load states) and the CPU (RUN).
// TESTING
//  1. rst 1 cycle; bytes 03,00,21,43,65 -> mem[0..5]=1,2,3,4,5,6; cpu_rst falls 1 cycle after
//     last DATA_HI; ld_ready pattern 1,1,(1,0)x3.
//  2. LEN=0 (bytes 00,00) -> RUN 1 cycle after HDR_HI; mem unchanged; bus_rdata@addr 0 = prior value.
//  3. RUN: bus_we=1, addr=0x037, wdata=A -> same-cycle rdata=old, next cycle rdata=A
//     (0x037 mod 256 = 0x37); bus_we during load -> no write.
//  4. ld_start in RUN with ld_valid=1, data=05 -> byte not taken; cpu_rst=1 next cycle;
//     state HDR_LO; then reload of 1 byte (01,00,9F) -> mem[0]=F, mem[1]=9.
//  5. rst asserted in DATA_HI mid-load -> cpu_rst=1, ld_ready=1 in cycle after rst drops,
//     written nibbles kept.
//  6. CHECKSUM_EN: 01,00,5A,checksum 5B -> RUN; checksum 00 -> load_err=1, cpu_rst stays 1
//     until ld_start.

Source files
------------

// File: rtl/nibble_bus_pkg.sv
// Shared types and constants for the nibble CPU memory/loader slice.
package nibble_bus_pkg;

  localparam int NIB_W      = 4;
  localparam int BUS_ADDR_W = 12;

  // CPU address-map slots: three instruction-fetch nibbles, then the data nibble
  localparam int FETCH_SLOT_FIRST = 0;
  localparam int FETCH_SLOT_LAST  = 2;
  localparam int DATA_SLOT        = 3;

  typedef enum logic [2:0] {
    HDR_LO,
    HDR_HI,
    DATA_LO,
    DATA_HI,
    CSUM,
    RUN,
    ERROR
  } loader_state_t;

  // Byte count of the image: low header byte plus the low nibble of the high header byte
  function automatic logic [BUS_ADDR_W-1:0] header_len(input logic [7:0] lo_byte,
                                                       input logic [3:0] hi_nib);
    return {hi_nib, lo_byte};
  endfunction

endpackage

// File: rtl/nibble_ram.sv
// Nibble-wide storage: one synchronous write port, one asynchronous read port.
module nibble_ram
  import nibble_bus_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH),
  parameter int DW    = NIB_W
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Write lands at the clock edge, so a same-address read sees the old nibble this cycle
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/nibble_mem_loader.sv
// Program/data memory for the nibble CPU with a byte-stream image loader in front.
// The CPU is held in reset until the image has been loaded.
// Build option: define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte;
// a bad checksum parks the loader in ERROR with load_err raised.
module nibble_mem_loader
  import nibble_bus_pkg::*;
#(
  parameter int MEM_NIBBLES = 256,
  parameter int ADDR_W      = BUS_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_we,
  input  logic [NIB_W-1:0]  bus_wdata,
  output logic [NIB_W-1:0]  bus_rdata,
  output logic              cpu_rst,
  output logic              load_done,
  output logic              load_err
);

  localparam int PTR_W = $clog2(MEM_NIBBLES);

`ifdef LOADER_CHECKSUM_EN
  localparam loader_state_t POST_DATA = CSUM;
`else
  localparam loader_state_t POST_DATA = RUN;
`endif

  loader_state_t         state;
  logic [PTR_W-1:0]      ptr;
  logic [BUS_ADDR_W-1:0] len;
  logic [BUS_ADDR_W-1:0] count;
  logic [NIB_W-1:0]      hi_nib;
  logic                  restart;
  logic                  accept;
  logic [BUS_ADDR_W:0]   count_next;
  logic                  data_last;
  logic [PTR_W-1:0]      bus_idx;
  logic                  unused_bus_hi;
  logic                  wr_en;
  logic [PTR_W-1:0]      wr_addr;
  logic [NIB_W-1:0]      wr_data;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            csum;
`endif

  // rst and ld_start both restart the loader and block any byte offered that cycle
  assign restart       = rst | ld_start;
  assign accept        = ld_valid & ld_ready;
  assign count_next    = {1'b0, count} + {{BUS_ADDR_W{1'b0}}, 1'b1};
  assign data_last     = !(count_next < {1'b0, len});
  assign bus_idx       = bus_addr[PTR_W-1:0];
  assign unused_bus_hi = ^bus_addr[ADDR_W-1:PTR_W];

  // The loader can take a byte only in the header, low-data and checksum states
  always_comb begin
    ld_ready = 1'b0;
    if (!restart) begin
      case (state)
        HDR_LO, HDR_HI, DATA_LO: ld_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
        CSUM:                    ld_ready = 1'b1;
`endif
        default:                 ld_ready = 1'b0;
      endcase
    end
  end

  // The RAM write port belongs to the loader during load and to the CPU only in RUN
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = ptr;
    wr_data = ld_data[NIB_W-1:0];
    if (!restart) begin
      case (state)
        DATA_LO: wr_en = accept;
        DATA_HI: begin
          wr_en   = 1'b1;
          wr_data = hi_nib;
        end
        RUN: begin
          wr_en   = bus_we;
          wr_addr = bus_idx;
          wr_data = bus_wdata;
        end
        default: wr_en = 1'b0;
      endcase
    end
  end

  // Load sequencer: header, nibble pairs, optional checksum, then release the CPU
  always_ff @(posedge clk) begin
    if (restart) begin
      state     <= HDR_LO;
      cpu_rst   <= 1'b1;
      load_done <= 1'b0;
      ptr       <= '0;
      count     <= '0;
      len       <= '0;
`ifdef LOADER_CHECKSUM_EN
      load_err  <= 1'b0;
      csum      <= '0;
`endif
    end else begin
      case (state)
        HDR_LO: begin
          if (accept) begin
            len   <= header_len(ld_data, len[BUS_ADDR_W-1:8]);
            state <= HDR_HI;
`ifdef LOADER_CHECKSUM_EN
            csum  <= ld_data;
`endif
          end
        end
        HDR_HI: begin
          if (accept) begin
            len <= header_len(len[7:0], ld_data[3:0]);
`ifdef LOADER_CHECKSUM_EN
            csum <= csum ^ ld_data;
`endif
            if (header_len(len[7:0], ld_data[3:0]) == '0) begin
              state <= POST_DATA;
              if (POST_DATA == RUN) begin
                cpu_rst   <= 1'b0;
                load_done <= 1'b1;
              end
            end else begin
              state <= DATA_LO;
            end
          end
        end
        DATA_LO: begin
          if (accept) begin
            hi_nib <= ld_data[7:4];
            ptr    <= ptr + PTR_W'(1);
            state  <= DATA_HI;
`ifdef LOADER_CHECKSUM_EN
            csum   <= csum ^ ld_data;
`endif
          end
        end
        DATA_HI: begin
          ptr   <= ptr + PTR_W'(1);
          count <= count_next[BUS_ADDR_W-1:0];
          if (data_last) begin
            state <= POST_DATA;
            if (POST_DATA == RUN) begin
              cpu_rst   <= 1'b0;
              load_done <= 1'b1;
            end
          end else begin
            state <= DATA_LO;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CSUM: begin
          if (accept) begin
            if (ld_data == csum) begin
              state     <= RUN;
              cpu_rst   <= 1'b0;
              load_done <= 1'b1;
            end else begin
              state    <= ERROR;
              load_err <= 1'b1;
            end
          end
        end
        ERROR: state <= ERROR;
`endif
        RUN:     state <= RUN;
        default: state <= HDR_LO;
      endcase
    end
  end

`ifndef LOADER_CHECKSUM_EN
  assign load_err = 1'b0;
`endif

  nibble_ram #(
    .DEPTH (MEM_NIBBLES),
    .AW    (PTR_W),
    .DW    (NIB_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (bus_idx),
    .rdata (bus_rdata)
  );

endmodule

// File: tb/tb_nibble_mem_loader.sv
// Self-checking bench for nibble_mem_loader: directed loads, random images and
// random CPU writes checked against a nibble-array reference model.
module tb_nibble_mem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_start;
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic        ld_ready;
  logic [11:0] bus_addr;
  logic        bus_we;
  logic [3:0]  bus_wdata;
  logic [3:0]  bus_rdata;
  logic        cpu_rst;
  logic        load_done;
  logic        load_err;

  int checks   = 0;
  int failures = 0;

  logic [3:0] model_mem [256];
  bit         known     [256];
  logic [7:0] img [$];
  logic [7:0] t1 [5];
  logic [7:0] t1_csum;
  logic [7:0] rnd_byte;
  logic [11:0] rnd_addr;
  logic [3:0] rnd_nib;
  int         bi;
  bit         exp_rdy;

  nibble_mem_loader dut (
    .clk       (clk),
    .rst       (rst),
    .ld_start  (ld_start),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready),
    .bus_addr  (bus_addr),
    .bus_we    (bus_we),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .cpu_rst   (cpu_rst),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkMem(input string tag, input logic [11:0] addr);
    bus_addr = addr;
    #1;
    if (known[addr[7:0]]) checkOutput(tag, 16'(bus_rdata), 16'(model_mem[addr[7:0]]));
  endtask

  task automatic setModel(input int idx, input logic [3:0] val);
    model_mem[idx % 256] = val;
    known[idx % 256]     = 1'b1;
  endtask

  task automatic sendByte(input logic [7:0] b);
    int waited = 0;
    ld_valid = 1'b1;
    ld_data  = b;
    #1;
    while (!ld_ready && waited < 6) begin
      tick();
      waited++;
    end
    checkOutput("ld_ready_accept", 16'(ld_ready), 16'd1);
    tick();
    ld_valid = 1'b0;
    ld_data  = 8'($urandom);
  endtask

  task automatic pulseStart();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    #1;
  endtask

  // Streams header, image bytes (and checksum when enabled), then checks the CPU release
  task automatic loadImage(input logic [3:0] hdr_pad);
    int         len;
    logic [7:0] hdr_hi;
    logic [7:0] csum;
    len    = img.size();
    hdr_hi = {hdr_pad, 4'(len >> 8)};
    csum   = 8'(len) ^ hdr_hi;
    sendByte(8'(len));
    sendByte(hdr_hi);
    foreach (img[i]) begin
      sendByte(img[i]);
      setModel(2 * i, img[i][3:0]);
      setModel(2 * i + 1, img[i][7:4]);
      csum = csum ^ img[i];
    end
`ifdef LOADER_CHECKSUM_EN
    sendByte(csum);
`else
    $display("[TB] image of %0d bytes, xor %02h", len, csum);
    if (len != 0) begin
      checkOutput("cpu_rst_last_data_hi", 16'(cpu_rst), 16'd1);
      tick();
    end
`endif
    checkOutput("run_cpu_rst", 16'(cpu_rst), 16'd0);
    checkOutput("run_load_done", 16'(load_done), 16'd1);
    checkOutput("run_load_err", 16'(load_err), 16'd0);
    checkOutput("run_ld_ready", 16'(ld_ready), 16'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    ld_start  = 1'b0;
    ld_valid  = 1'b0;
    ld_data   = 8'h00;
    bus_addr  = 12'h000;
    bus_we    = 1'b0;
    bus_wdata = 4'h0;
    foreach (known[i]) known[i] = 1'b0;
    t1 = '{8'h03, 8'h00, 8'h21, 8'h43, 8'h65};

    // Reset state
    tick();
    checkOutput("rst_ld_ready", 16'(ld_ready), 16'd0);
    checkOutput("rst_cpu_rst", 16'(cpu_rst), 16'd1);
    checkOutput("rst_load_done", 16'(load_done), 16'd0);
    checkOutput("rst_load_err", 16'(load_err), 16'd0);
    rst = 1'b0;
    #1;
    checkOutput("hdr_lo_ready", 16'(ld_ready), 16'd1);

    // Directed 3-byte load with cycle-exact ready pattern 1,1,(1,0)x3
    bi      = 0;
    t1_csum = 8'h00;
    for (int c = 0; c < 8; c++) begin
      exp_rdy  = (c < 3) || (c % 2 == 0);
      ld_valid = exp_rdy;
      ld_data  = exp_rdy ? t1[bi] : 8'h00;
      #1;
      checkOutput("t1_ready", 16'(ld_ready), 16'(exp_rdy));
      checkOutput("t1_cpu_rst_held", 16'(cpu_rst), 16'd1);
      if (exp_rdy) begin
        t1_csum = t1_csum ^ t1[bi];
        bi++;
      end
      tick();
    end
    ld_valid = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    sendByte(t1_csum);
`endif
    checkOutput("t1_cpu_rst_fall", 16'(cpu_rst), 16'd0);
    checkOutput("t1_load_done", 16'(load_done), 16'd1);
    for (int i = 0; i < 3; i++) begin
      setModel(2 * i, t1[i + 2][3:0]);
      setModel(2 * i + 1, t1[i + 2][7:4]);
    end
    for (int a = 0; a < 6; a++) checkMem("t1_mem", 12'(a));

    // Zero-length image goes straight to RUN and leaves memory alone
    pulseStart();
    img.delete();
    loadImage(4'h0);
    checkMem("t2_mem0_kept", 12'h000);

    // CPU write in RUN: read-during-write shows old data, and the address wraps
    bus_addr  = 12'h037;
    bus_wdata = 4'h3;
    bus_we    = 1'b1;
    tick();
    setModel(8'h37, 4'h3);
    bus_wdata = 4'hA;
    #1;
    checkOutput("t3_rdw_old", 16'(bus_rdata), 16'h3);
    tick();
    bus_we = 1'b0;
    setModel(8'h37, 4'hA);
    checkMem("t3_new", 12'h037);
    checkMem("t3_alias", 12'h137);

    // Random image longer than memory: pointer wraps and overwrites from nibble 0
    pulseStart();
    img.delete();
    for (int i = 0; i < int'($urandom_range(129, 140)); i++) img.push_back(8'($urandom));
    loadImage(4'($urandom));
    for (int k = 0; k < 16; k++) checkMem("wrap_mem", 12'($urandom));

    // ld_start in RUN rejects the byte offered alongside it
    ld_valid = 1'b1;
    ld_data  = 8'h05;
    ld_start = 1'b1;
    #1;
    checkOutput("t4_start_ready", 16'(ld_ready), 16'd0);
    tick();
    ld_start = 1'b0;
    ld_valid = 1'b0;
    #1;
    checkOutput("t4_cpu_rst", 16'(cpu_rst), 16'd1);
    checkOutput("t4_load_done", 16'(load_done), 16'd0);
    checkOutput("t4_hdr_lo_ready", 16'(ld_ready), 16'd1);
    bus_addr  = 12'h180;
    bus_wdata = ~model_mem[8'h80];
    bus_we    = 1'b1;
    tick();
    tick();
    bus_we = 1'b0;
    checkMem("t4_no_cpu_write_in_load", 12'h080);
    img.delete();
    img.push_back(8'h9F);
    loadImage(4'h0);
    checkMem("t4_mem0", 12'h000);
    checkMem("t4_mem1", 12'h001);

    // Reset in DATA_HI mid-load keeps already written nibbles
    pulseStart();
    rnd_byte = 8'($urandom);
    sendByte(8'h04);
    sendByte(8'h00);
    sendByte(rnd_byte);
    setModel(0, rnd_byte[3:0]);
    known[1] = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("t5_rst_ready", 16'(ld_ready), 16'd0);
    tick();
    rst = 1'b0;
    #1;
    checkOutput("t5_cpu_rst", 16'(cpu_rst), 16'd1);
    checkOutput("t5_load_done", 16'(load_done), 16'd0);
    checkOutput("t5_ready_after_rst", 16'(ld_ready), 16'd1);
    checkMem("t5_mem0_kept", 12'h000);

    // Fresh random load after the interrupted one must start at nibble 0
    img.delete();
    for (int i = 0; i < int'($urandom_range(1, 8)); i++) img.push_back(8'($urandom));
    loadImage(4'($urandom));
    for (int a = 0; a < 2 * img.size(); a++) checkMem("t5_reload_mem", 12'(a));

    // Random CPU writes across the full 12-bit bus address range
    for (int k = 0; k < 20; k++) begin
      rnd_addr  = 12'($urandom);
      rnd_nib   = 4'($urandom);
      bus_addr  = rnd_addr;
      bus_wdata = rnd_nib;
      bus_we    = 1'b1;
      #1;
      if (known[rnd_addr[7:0]])
        checkOutput("rand_rdw_old", 16'(bus_rdata), 16'(model_mem[rnd_addr[7:0]]));
      tick();
      bus_we = 1'b0;
      setModel(int'(rnd_addr[7:0]), rnd_nib);
      checkMem("rand_wr_new", rnd_addr);
    end

`ifdef LOADER_CHECKSUM_EN
    // Good checksum releases the CPU; bad checksum parks in ERROR until ld_start
    pulseStart();
    sendByte(8'h01);
    sendByte(8'h00);
    sendByte(8'h5A);
    sendByte(8'h5B);
    checkOutput("t6_good_cpu_rst", 16'(cpu_rst), 16'd0);
    checkOutput("t6_good_err", 16'(load_err), 16'd0);
    setModel(0, 4'hA);
    setModel(1, 4'h5);
    checkMem("t6_mem0", 12'h000);
    pulseStart();
    sendByte(8'h01);
    sendByte(8'h00);
    sendByte(8'h5A);
    sendByte(8'h00);
    checkOutput("t6_bad_err", 16'(load_err), 16'd1);
    checkOutput("t6_bad_cpu_rst", 16'(cpu_rst), 16'd1);
    checkOutput("t6_bad_ready", 16'(ld_ready), 16'd0);
    tick();
    tick();
    tick();
    checkOutput("t6_err_sticky", 16'(load_err), 16'd1);
    checkOutput("t6_load_done", 16'(load_done), 16'd0);
    pulseStart();
    checkOutput("t6_err_cleared", 16'(load_err), 16'd0);
    checkOutput("t6_restart_ready", 16'(ld_ready), 16'd1);
`else
    checkOutput("load_err_tied_low", 16'(load_err), 16'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
